// File: rtl/cover_toggle_drain.sv
// Toggle-coverage sink: one saturating hit counter per cover point, drained on
// request as ascending (index, count) records over a valid/ready stream.
module cover_toggle_drain #(
    parameter int unsigned WIDTH       = 64,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   valid,
    input  logic               dump_req,
    output logic               busy,
    output logic               dump_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_index,
    output logic [CNT_W-1:0]   out_count
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_d;
    logic [CNT_W-1:0]   cnt [WIDTH];
    logic [CNT_W-1:0]   cur_cnt_c;
    logic               capture_c;
    logic               last_c;

    assign cur_cnt_c = cnt[idx];
    assign capture_c = (state == SCAN) && (cur_cnt_c != '0);
    assign last_c    = (idx == LAST_IDX);

    // Next-state and scan pointer.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        unique case (state)
            IDLE: begin
                if (dump_req) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (capture_c) begin
                    state_d = EMIT;
                end else if (last_c) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx + IDX_W'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_c) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and registered outputs; the record latches only on capture
    // so it stays stable through any stall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_count <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            busy      <= (state_d != IDLE);
            dump_done <= (state == DONE);
            out_valid <= (state_d == EMIT);
            if (capture_c) begin
                out_index <= COVER_INDEX + 64'(idx);
                out_count <= cur_cnt_c;
            end
        end
    end

    // Hit counters; a captured counter restarts from the coincident hit.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!reset) begin
                cnt[i] <= '0;
            end else if (capture_c && (idx == IDX_W'(i))) begin
                cnt[i] <= CNT_W'(valid[i]);
            end else if (valid[i] && (cnt[i] != CNT_MAX)) begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cover_toggle_drain.sv
// Randomized bench for cover_toggle_drain against a per-point hit-count model.
module tb_cover_toggle_drain;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = 8;
    localparam logic [63:0] CIDX  = 64'd100;
    localparam int          SAT   = 255;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [WIDTH-1:0]   vld = '0;
    logic               dump_req = 1'b0;
    logic               busy;
    logic               dump_done;
    logic               out_valid;
    logic               ready = 1'b0;
    logic [63:0]        out_index;
    logic [CNT_W-1:0]   out_count;

    int n_cmp = 0;
    int n_err = 0;
    int mcnt [WIDTH];
    logic [63:0] exp_idx_q [$];
    logic [63:0] exp_cnt_q [$];

    cover_toggle_drain #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (CIDX),
        .CNT_W       (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .valid     (vld),
        .dump_req  (dump_req),
        .busy      (busy),
        .dump_done (dump_done),
        .out_valid (out_valid),
        .out_ready (ready),
        .out_index (out_index),
        .out_count (out_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge; the model accumulates hits exactly as the inputs stood at the edge.
    task automatic tick();
        @(posedge clock);
        for (int i = 0; i < WIDTH; i++) begin
            if (!reset) mcnt[i] = 0;
            else if (vld[i]) mcnt[i] = (mcnt[i] + 1 > SAT) ? SAT : mcnt[i] + 1;
        end
        #1;
    endtask

    function automatic logic [63:0] sparse_hits();
        logic [63:0] r;
        r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        return r;
    endfunction

    // mode 0: ready always high (cycle count checked); 1: random ready;
    // 2: first record stalled 4 cycles. cb >= 0 hits bit cb in its scan cycle.
    task automatic drain(input int mode, input int cb, input bit inject);
        int  n_rec;
        int  cyc;
        int  stall_left;
        bit  done;
        bit  stalled;
        bit  injected;
        logic [63:0] held_idx;
        logic [63:0] held_cnt;
        exp_idx_q.delete();
        exp_cnt_q.delete();
        for (int i = 0; i < WIDTH; i++) begin
            if (mcnt[i] != 0) begin
                exp_idx_q.push_back(CIDX + 64'(i));
                exp_cnt_q.push_back(64'(mcnt[i]));
            end
            mcnt[i] = 0;
        end
        n_rec = exp_idx_q.size();
        vld = '0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        cyc = 0; done = 0; stalled = 0; injected = 0; stall_left = 4;
        held_idx = '0; held_cnt = '0;
        while (cyc < 2000) begin
            if (dump_done) begin
                done = 1;
                check("busy_at_done", 64'(busy), 64'd0);
                break;
            end
            check("busy", 64'(busy), 64'd1);
            dump_req = 1'b0;
            if (out_valid) begin
                if (stalled) begin
                    check("hold_index", out_index, held_idx);
                    check("hold_count", 64'(out_count), held_cnt);
                end
                if (inject && !injected) begin
                    dump_req = 1'b1;
                    injected = 1;
                end
                if (mode == 0) ready = 1'b1;
                else if (mode == 1) ready = ($urandom_range(0, 2) != 0);
                else begin
                    ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                if (ready) begin
                    stalled = 0;
                    if (exp_idx_q.size() == 0) begin
                        check("extra_record", out_index, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("rec_index", out_index, exp_idx_q.pop_front());
                        check("rec_count", 64'(out_count), exp_cnt_q.pop_front());
                    end
                end else begin
                    stalled = 1;
                    held_idx = out_index;
                    held_cnt = 64'(out_count);
                end
            end else begin
                if (stalled) check("valid_dropped", 64'(out_valid), 64'd1);
                stalled = 0;
                ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            vld = '0;
            if (cb >= 0 && cyc == cb) vld[cb] = 1'b1;
            tick();
            cyc++;
        end
        vld = '0;
        dump_req = 1'b0;
        check("done_seen", 64'(done), 64'd1);
        check("records_left", 64'(exp_idx_q.size()), 64'd0);
        if (mode == 0) check("drain_cycles", 64'(cyc), 64'(WIDTH + n_rec + 1));
        tick();
        check("done_one_cycle", 64'(dump_done), 64'd0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < WIDTH; i++) mcnt[i] = 0;

        // Reset holds everything at zero even with hits present.
        reset = 1'b0;
        vld = sparse_hits();
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(dump_done), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_index", out_index, 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        reset = 1'b1;
        vld = '0;
        drain(0, -1, 0);

        // Basic drain, then an empty one.
        for (int k = 0; k < 5; k++) begin
            vld = '0;
            vld[3] = 1'b1;
            if (k == 0) vld[63] = 1'b1;
            tick();
        end
        vld = '0;
        drain(0, -1, 0);
        drain(0, -1, 0);

        // Saturation.
        vld = '0;
        vld[0] = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        vld = '0;
        check("sat_model", 64'(mcnt[0]), 64'd255);
        drain(0, -1, 0);

        // Coincident hit on the scanned bit plus a stalled consumer.
        vld = '0;
        vld[7] = 1'b1;
        tick();
        tick();
        vld = '0;
        drain(2, 7, 0);
        vld[7] = 1'b1;
        tick();
        tick();
        vld = '0;
        check("coinc_model", 64'(mcnt[7]), 64'd3);
        drain(0, -1, 0);

        // Request during EMIT is dropped: no second drain follows.
        vld = '0;
        vld[20] = 1'b1;
        vld[50] = 1'b1;
        tick();
        vld = '0;
        drain(0, -1, 1);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            if (dump_done || busy) seen++;
            tick();
        end
        check("busy_req_ignored", 64'(seen), 64'd0);

        // Reset during EMIT aborts and clears.
        vld = '0;
        vld[2] = 1'b1;
        vld[40] = 1'b1;
        tick();
        vld = '0;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        ready = 1'b0;
        for (int k = 0; k < 100 && !out_valid; k++) tick();
        check("mid_emit_reached", 64'(out_valid), 64'd1);
        reset = 1'b0;
        tick();
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(dump_done), 64'd0);
        reset = 1'b1;
        tick();
        check("abort_no_done", 64'(dump_done), 64'd0);
        drain(0, -1, 0);

        // Random traffic with alternating consumer behaviour.
        for (int r = 0; r < 8; r++) begin
            int len;
            len = int'($urandom_range(10, 60));
            for (int k = 0; k < len; k++) begin
                vld = sparse_hits();
                tick();
            end
            vld = '0;
            drain(r % 2, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
